point_uart_tx: RTL
==================

// Module: point_uart_tx
// PURPOSE
//  Transmit side of the point-detection path. Collects per-frame point coordinates from the
//  multi-point finder (PT_H/PT_V strobes) into ping-pong buffers. On each frame boundary it
//  sends them to the host PC as one UART packet (8N1, LSB first) for motion-capture tracking.
//  Sits between the point finder and the board UART TX pin.
// PARAMETERS
//  CLK_FREQ    50_000_000  CLK frequency in Hz
//  BAUD        115200      UART bit rate; BIT_CYCLES = CLK_FREQ/BAUD (integer divide, >=4)
//  MAX_POINTS  8           points buffered per frame, 1..127
// PORTS
//  CLK       in   1   system clock; the only clock
//  RESET_N   in   1   asynchronous, active-low reset
//  VGA_VS    in   1   vertical sync, CLK domain; a rising edge closes the current frame
//  PT_VALID  in   1   one-cycle strobe: PT_H/PT_V hold a detected point
//  PT_H      in   16  point horizontal coordinate
//  PT_V      in   16  point vertical coordinate
//  UART_TXD  out  1   serial line, idles high
//  BUSY      out  1   packet in progress (read bank owned by TX)
//  DROP_CNT  out  8   frames discarded because TX was busy; saturates at 8'hFF
// BEHAVIOUR
//  Reset (async): UART_TXD=1, BUSY=0, DROP_CNT=0, FRAME_ID=0, both bank counts=0, FSM=IDLE.
//   Reset mid-byte forces UART_TXD high immediately and abandons the packet.
//  Write side: PT_VALID stores {PT_H,PT_V} at write-bank index wcnt, then wcnt++.
//   When wcnt==MAX_POINTS, further points are ignored and the frame OVF flag is set.
//  Frame close: rVS registered; close = VGA_VS & ~rVS.
//   A PT_VALID in the close cycle belongs to the closing frame.
//   If FSM==IDLE: swap banks, latch count/OVF/FRAME_ID, clear wcnt/OVF; BUSY=1 next cycle.
//   Else: discard write bank (wcnt=0, OVF=0) and increment DROP_CNT.
//   FRAME_ID increments (mod 256) on every close, sent or dropped, so the host sees gaps.
//  Packet bytes, in order:
//   8'hA5, FRAME_ID, {OVF,count[6:0]}, then per point H[15:8],H[7:0],V[15:8],V[7:0],
//   then CHK when enabled. A frame with 0 points still sends its header packet.
//  FSM: IDLE -> HDR -> FID -> CNT -> PT (byte idx 0..3, point idx 0..count-1) -> [CHK] -> IDLE.
//   Each state loads one byte into the serializer on the cycle ready=1.
//   It advances when the serializer accepts the byte (start & ready).
//  Serializer: start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts BIT_CYCLES.
//   ready rises on the cycle the stop bit ends; bytes go back-to-back with no idle gap.
//  Latency: the UART_TXD start-bit fall occurs 2 CLK after the close cycle.
//  BUSY drops the cycle after the last stop bit completes. A close in that same cycle is
//   treated as busy (dropped).
// CONFIGURATION
//  POINT_TX_CHECKSUM_EN defined: append CHK = XOR of all preceding packet bytes, header
//   included.
//  Not defined: the packet ends after the last point byte; the CHK state is not built.
// STRUCTURE
//  Package point_tx_pkg holds:
//   - PKT_HDR = 8'hA5
//   - FSM state enum {IDLE,HDR,FID,CNT,PT,CHK}
//   - point record typedef {h[15:0], v[15:0]}
//  Sub-module uart_tx_byte (params CLK_FREQ, BAUD), an 8N1 serializer.
//   Ports: CLK, RESET_N, start, data[7:0], ready, txd.
//  Buffers: 2 x MAX_POINTS x 32-bit register banks selected by a bank bit.
// TESTING  (CLK_FREQ=1_000_000, BAUD=100_000 -> 10 cycles/bit; decode UART_TXD with a
//   bench model)
//  1 Reset held, VGA_VS toggling -> UART_TXD=1, BUSY=0, DROP_CNT=0; release -> line stays
//    idle.
//  2 Points (100,200),(320,240), then VS rise -> bytes A5 00 02 00 64 00 C8 01 40 00 F0.
//    With CHECKSUM_EN, a trailing BA follows.
//  3 Next frame with no points -> A5 01 00 (+A4 with CHECKSUM_EN); BUSY low afterwards.
//  4 10 points in one frame, MAX_POINTS=8 -> count byte 88; only the first 8 points are sent.
//  5 Second VS rise while packet 2 is still sending -> DROP_CNT=1.
//    The following packet carries FRAME_ID 02; dropped points are never sent.
//  6 RESET_N low during the 5th byte -> UART_TXD=1 at once, BUSY=0.
//    After release, the next packet uses FRAME_ID 00.

Source files
------------

// File: rtl/point_tx_pkg.sv
// ============================================================================
// Module      : point_tx_pkg
// Description : Shared constants and types for the point UART transmit path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package point_tx_pkg;

  localparam logic [7:0] PKT_HDR = 8'hA5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    FID  = 3'd2,
    CNT  = 3'd3,
    PT   = 3'd4,
    CHK  = 3'd5
  } tx_state_e;

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] v;
  } point_t;

  // Wire order of a point on the link: H high, H low, V high, V low.
  function automatic logic [7:0] pt_byte(input point_t p, input logic [1:0] idx);
    case (idx)
      2'd0:    return p.h[15:8];
      2'd1:    return p.h[7:0];
      2'd2:    return p.v[15:8];
      default: return p.v[7:0];
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_byte.sv
// ============================================================================
// Module      : uart_tx_byte
// Description : 8N1 byte serializer, LSB first; ready allows back-to-back bytes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_byte #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       txd
);

  localparam int c_BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int c_CW         = $clog2(c_BIT_CYCLES);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_BIT_CYCLES - 1);

  logic            r_active;
  logic [9:0]      r_shift;
  logic [c_CW-1:0] r_cnt;
  logic [3:0]      r_bit;

  // Ready in the final stop-bit cycle so the next start bit follows with no gap.
  assign ready = ~r_active | ((r_bit == 4'd9) & (r_cnt == c_LAST));
  assign txd   = r_active ? r_shift[0] : 1'b1;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_active <= 1'b0;
      r_shift  <= '1;
      r_cnt    <= '0;
      r_bit    <= '0;
    end else if (start && ready) begin
      r_active <= 1'b1;
      r_shift  <= {1'b1, data, 1'b0};
      r_cnt    <= '0;
      r_bit    <= '0;
    end else if (r_active) begin
      if (r_cnt == c_LAST) begin
        r_cnt <= '0;
        if (r_bit == 4'd9) begin
          r_active <= 1'b0;
        end else begin
          r_bit   <= r_bit + 4'd1;
          r_shift <= {1'b1, r_shift[9:1]};
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/point_uart_tx.sv
// ============================================================================
// Module      : point_uart_tx
// Description : Ping-pong buffers frame points and ships each frame as a UART
//               packet. Define POINT_TX_CHECKSUM_EN to append an XOR checksum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module point_uart_tx
  import point_tx_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int MAX_POINTS = 8
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        VGA_VS,
  input  logic        PT_VALID,
  input  logic [15:0] PT_H,
  input  logic [15:0] PT_V,
  output logic        UART_TXD,
  output logic        BUSY,
  output logic [7:0]  DROP_CNT
);

  localparam int         c_IW   = (MAX_POINTS > 1) ? $clog2(MAX_POINTS) : 1;
  localparam logic [6:0] c_MAXP = 7'(MAX_POINTS);

  localparam logic [2:0] S_IDLE = 3'(IDLE);
  localparam logic [2:0] S_HDR  = 3'(HDR);
  localparam logic [2:0] S_FID  = 3'(FID);
  localparam logic [2:0] S_CNT  = 3'(CNT);
  localparam logic [2:0] S_PT   = 3'(PT);
`ifdef POINT_TX_CHECKSUM_EN
  localparam logic [2:0] S_CHK  = 3'(CHK);
  localparam logic [2:0] c_TAIL = S_CHK;
`else
  localparam logic [2:0] c_TAIL = S_IDLE;
`endif

  logic       r_vs;
  logic       r_wbank;
  logic [6:0] r_wcnt;
  logic       r_wovf;
  logic [6:0] r_rcnt;
  logic       r_rovf;
  logic [7:0] r_fid;
  logic [7:0] r_tx_fid;
  logic [7:0] r_drop;
  logic       r_busy;
  logic [2:0] r_state;
  logic [6:0] r_pidx;
  logic [1:0] r_bidx;
  logic [7:0] r_chk;
  point_t     r_bank [2][MAX_POINTS];

  logic       w_close;
  logic       w_accept;
  logic       w_room;
  logic       w_wr;
  logic       w_ready;
  logic       w_start;
  logic [7:0] w_byte;
  point_t     w_rd_pt;

  assign w_close  = VGA_VS & ~r_vs;
  assign w_accept = w_close & ~r_busy;
  assign w_room   = (r_wcnt < c_MAXP);
  assign w_wr     = PT_VALID & w_room;
  assign w_start  = (r_state != S_IDLE) & w_ready;
  assign w_rd_pt  = r_bank[~r_wbank][r_pidx[c_IW-1:0]];

  assign BUSY     = r_busy;
  assign DROP_CNT = r_drop;

  always_ff @(posedge CLK) begin
    if (w_wr) begin
      r_bank[r_wbank][r_wcnt[c_IW-1:0]] <= {PT_H, PT_V};
    end
  end

  // A point strobed in the close cycle is counted into the closing frame.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_vs     <= 1'b0;
      r_wbank  <= 1'b0;
      r_wcnt   <= '0;
      r_wovf   <= 1'b0;
      r_rcnt   <= '0;
      r_rovf   <= 1'b0;
      r_fid    <= '0;
      r_tx_fid <= '0;
      r_drop   <= '0;
    end else begin
      r_vs <= VGA_VS;
      if (w_close) begin
        r_wcnt <= '0;
        r_wovf <= 1'b0;
        r_fid  <= r_fid + 8'd1;
        if (w_accept) begin
          r_wbank  <= ~r_wbank;
          r_rcnt   <= r_wcnt + 7'(w_wr);
          r_rovf   <= r_wovf | (PT_VALID & ~w_room);
          r_tx_fid <= r_fid;
        end else if (r_drop != 8'hFF) begin
          r_drop <= r_drop + 8'd1;
        end
      end else if (PT_VALID) begin
        if (w_room) begin
          r_wcnt <= r_wcnt + 7'd1;
        end else begin
          r_wovf <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_byte = PKT_HDR;
    case (r_state)
      S_FID:   w_byte = r_tx_fid;
      S_CNT:   w_byte = {r_rovf, r_rcnt};
      S_PT:    w_byte = pt_byte(w_rd_pt, r_bidx);
`ifdef POINT_TX_CHECKSUM_EN
      S_CHK:   w_byte = r_chk;
`endif
      default: w_byte = PKT_HDR;
    endcase
  end

  // BUSY stays up after the FSM returns to idle until the last stop bit ends.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_pidx  <= '0;
      r_bidx  <= '0;
      r_chk   <= '0;
    end else if (w_accept) begin
      r_busy  <= 1'b1;
      r_state <= S_HDR;
    end else if (w_start) begin
      r_chk <= (r_state == S_HDR) ? w_byte : (r_chk ^ w_byte);
      case (r_state)
        S_HDR: r_state <= S_FID;
        S_FID: r_state <= S_CNT;
        S_CNT: begin
          r_pidx  <= '0;
          r_bidx  <= '0;
          r_state <= (r_rcnt == 7'd0) ? c_TAIL : S_PT;
        end
        S_PT: begin
          r_bidx <= r_bidx + 2'd1;
          if (r_bidx == 2'd3) begin
            if (r_pidx == r_rcnt - 7'd1) begin
              r_state <= c_TAIL;
            end else begin
              r_pidx <= r_pidx + 7'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end else if ((r_state == S_IDLE) && w_ready) begin
      r_busy <= 1'b0;
    end
  end

  uart_tx_byte #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_ser (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .start   (w_start),
    .data    (w_byte),
    .ready   (w_ready),
    .txd     (UART_TXD)
  );

endmodule

`default_nettype wire
